// File: rtl/dmem_mmio_pkg.sv
// Shared memory map for the CPU data port: MMIO addresses, STATUS bit layout, address decode helper.
// Latency: none, constants and a purely combinational helper function.
// Backpressure: not applicable, no storage or handshake here.
package mem_map_pkg;

    // MMIO register addresses (word aligned; byte offset bits are ignored on decode)
    localparam logic [31:0] TXDATA_ADDR = 32'hFFFF_FF00;
    localparam logic [31:0] STATUS_ADDR = 32'hFFFF_FF04;
    localparam logic [31:0] CYCLES_ADDR = 32'hFFFF_FF08;

    // STATUS register bit positions
    localparam int ST_FULL    = 0;
    localparam int ST_EMPTY   = 1;
    localparam int ST_CNT_LSB = 2;
    localparam int ST_CNT_MSB = 6;
    localparam int ST_OVF     = 7;

    typedef enum logic [2:0] {
        RGN_NONE,
        RGN_RAM,
        RGN_TX,
        RGN_STATUS,
        RGN_CYCLES
    } region_e;

    // Classify a byte address. ram_bytes is a multiple of 4, so masking the
    // byte offset before the range compare gives the same answer as not masking.
    function automatic region_e decode(input logic [31:0] addr, input logic [31:0] ram_bytes);
        logic [31:0] wa;
        wa = addr & 32'hFFFF_FFFC;
        if (wa < ram_bytes)          return RGN_RAM;
        else if (wa == TXDATA_ADDR)  return RGN_TX;
        else if (wa == STATUS_ADDR)  return RGN_STATUS;
        else if (wa == CYCLES_ADDR)  return RGN_CYCLES;
        else                         return RGN_NONE;
    endfunction

endpackage

// File: rtl/dmem_mmio_if.sv
// CPU data port plus TX byte stream, bundled for dmem_mmio.
// Latency: none, wires only.
// Backpressure: tx_valid/tx_ready handshake on the TX stream; CPU side never stalls.
// Ports: MemWrite/ALUResult/WriteData/ReadData (CPU), tx_data/tx_valid/tx_ready (byte consumer).
interface dmem_mmio_if;
    logic        MemWrite;
    logic [31:0] ALUResult;
    logic [31:0] WriteData;
    logic [31:0] ReadData;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;

    // master: CPU + byte consumer side (the environment driving the memory block)
    modport master (
        output MemWrite, ALUResult, WriteData, tx_ready,
        input  ReadData, tx_data, tx_valid
    );

    // slave: the memory/MMIO block
    modport slave (
        input  MemWrite, ALUResult, WriteData, tx_ready,
        output ReadData, tx_data, tx_valid
    );
endinterface

// File: rtl/dmem_mmio_sync_fifo.sv
// Synchronous FIFO with occupancy count; head word is visible combinationally on dout.
// Latency: a push is visible at dout/!empty one cycle later.
// Backpressure: push to full is dropped unless a pop happens in the same cycle; pop on empty ignored.
// Ports: clk, reset (sync, active high), push/din, pop/dout, full, empty, count (0..DEPTH).
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic [WIDTH-1:0]         din,
    output logic                     full,
    input  logic                     pop,
    output logic [WIDTH-1:0]         dout,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             do_push, do_pop;

    assign full  = (count_q == CW'(DEPTH));
    assign empty = (count_q == '0);
    assign count = count_q;
    // Head reads as zero when empty so a flushed FIFO presents a clean bus.
    assign dout  = empty ? '0 : mem_q[rd_ptr_q];

    // When full, a same-cycle pop frees the head slot, which is exactly where
    // wr_ptr points, so the push may proceed.
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);

    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
        if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage is not reset; validity is tracked by count.
    always_ff @(posedge clk) begin
        if (do_push && !reset) mem_q[wr_ptr_q] <= din;
    end

endmodule

// File: rtl/dmem_mmio.sv
// Data memory for a single-cycle CPU with MMIO TX byte FIFO, STATUS and free-running CYCLES counter.
// Latency: loads are combinational from ALUResult; stores and register writes take effect at the edge.
// Backpressure: TX stream uses tx_valid/tx_ready; stores to a full FIFO are dropped and flagged in STATUS.ovf.
// Ports: clk, reset (sync, active high), bus (dmem_mmio_if.slave: CPU data port + TX stream).
module dmem_mmio
    import mem_map_pkg::*;
#(
    parameter int RAM_WORDS  = 64,
    parameter int FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        reset,
    dmem_mmio_if.slave  bus
);
    localparam int          RAM_AW    = $clog2(RAM_WORDS);
    localparam int          CW        = $clog2(FIFO_DEPTH) + 1;
    localparam logic [31:0] RAM_BYTES = 32'(RAM_WORDS * 4);

    region_e          rgn;
    logic [RAM_AW-1:0] ram_idx;
    logic [31:0]      ram_q [RAM_WORDS];

    logic             wr_ram, wr_tx, wr_status, wr_cycles;
    logic             tx_pop;
    logic             fifo_full, fifo_empty;
    logic [7:0]       fifo_dout;
    logic [CW-1:0]    fifo_count;

    logic             ovf_q, ovf_d;
    logic [31:0]      cycles_q, cycles_d;
    logic [31:0]      status;
    logic [31:0]      rdata;

    // Address decode
    assign rgn     = decode(bus.ALUResult, RAM_BYTES);
    assign ram_idx = bus.ALUResult[RAM_AW+1:2];

    // Reset overrides every same-cycle write.
    assign wr_ram    = bus.MemWrite & ~reset & (rgn == RGN_RAM);
    assign wr_tx     = bus.MemWrite & ~reset & (rgn == RGN_TX);
    assign wr_status = bus.MemWrite & ~reset & (rgn == RGN_STATUS);
    assign wr_cycles = bus.MemWrite & ~reset & (rgn == RGN_CYCLES);

    // TX FIFO
    assign tx_pop = ~fifo_empty & bus.tx_ready & ~reset;

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_tx_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (wr_tx),
        .din   (bus.WriteData[7:0]),
        .full  (fifo_full),
        .pop   (tx_pop),
        .dout  (fifo_dout),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    assign bus.tx_valid = ~fifo_empty;
    assign bus.tx_data  = fifo_dout;

    // Sticky overflow and cycle counter next-state
    always_comb begin
        ovf_d = ovf_q;
        if (wr_status) ovf_d = 1'b0;
        // A dropped push sets ovf after the clear so that set wins.
        if (wr_tx && fifo_full && !tx_pop) ovf_d = 1'b1;

        cycles_d = wr_cycles ? bus.WriteData : cycles_q + 32'd1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ovf_q    <= 1'b0;
            cycles_q <= '0;
        end else begin
            ovf_q    <= ovf_d;
            cycles_q <= cycles_d;
        end
    end

    // RAM: contents survive reset; read is asynchronous so a same-cycle
    // load of a word being stored still returns the old value.
    always_ff @(posedge clk) begin
        if (wr_ram) ram_q[ram_idx] <= bus.WriteData;
    end

    // STATUS word
    always_comb begin
        status                        = '0;
        status[ST_FULL]               = fifo_full;
        status[ST_EMPTY]              = fifo_empty;
        status[ST_CNT_MSB:ST_CNT_LSB] = 5'(fifo_count);
        status[ST_OVF]                = ovf_q;
    end

    // Read mux; TXDATA and unmapped addresses read as zero.
    always_comb begin
        rdata = '0;
        case (rgn)
            RGN_RAM:    rdata = ram_q[ram_idx];
            RGN_STATUS: rdata = status;
            RGN_CYCLES: rdata = cycles_q;
            default:    rdata = '0;
        endcase
    end

    assign bus.ReadData = rdata;

endmodule
